// File: rtl/de2_115_web_qsys_pio_out_pkg.sv
// Shared register map and helpers for the parallel output port.
package de2_115_web_qsys_pio_out_pkg;

  // Word addresses of the four slave registers.
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  // Bit position of the busy flag in the PULSE read word.
  localparam int BUSY_BIT = 31;

  // Width of the self-timing pulse counter.
  localparam int CNT_W = 16;

endpackage

// File: rtl/de2_115_web_qsys_pio_pulse_timer.sv
// Pulse timer: holds the active pulse mask and its countdown. A load ORs new
// bits into the mask and restarts the full window for every active bit.
module de2_115_web_qsys_pio_pulse_timer
  import de2_115_web_qsys_pio_out_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pulse_mask,
  output logic [WIDTH-1:0] pulse_mask_next,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: reload on a nonzero load, otherwise count down and drop the
  // mask once the counter has reached zero. The counter never wraps.
  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (load && (mask != '0)) begin
      mask_d = mask_q | mask;
      cnt_d  = RELOAD;
    end else if (mask_q != '0) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        mask_d = '0;
      end
    end
  end

  // State registers; reset aborts any pulse in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse_mask      = mask_q;
  assign pulse_mask_next = mask_d;
  assign busy            = (mask_q != '0);

endmodule

// File: rtl/de2_115_web_qsys_pio_out.sv
// Avalon-MM parallel output port with data/set/clear registers and a
// self-timing pulse register. out_port = data_reg | pulse_mask, registered.
module de2_115_web_qsys_pio_out
  import de2_115_web_qsys_pio_out_pkg::*;
#(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             write_en;
  logic [WIDTH-1:0] wd;
  logic             pulse_load;
  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] pulse_mask_next;
  logic             busy;

  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Upper write-data bits are intentionally ignored for narrow ports.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign write_en   = chipselect && !write_n;
  assign wd         = writedata[WIDTH-1:0];
  assign pulse_load = write_en && (address == ADDR_PULSE);

  de2_115_web_qsys_pio_pulse_timer #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk             (clk),
    .reset           (reset),
    .load            (pulse_load),
    .mask            (wd),
    .pulse_mask      (pulse_mask),
    .pulse_mask_next (pulse_mask_next),
    .busy            (busy)
  );

  // Data register update: plain write, atomic set, atomic clear.
  always_comb begin
    data_d = data_q;
    if (write_en) begin
      case (address)
        ADDR_DATA:  data_d = wd;
        ADDR_SET:   data_d = data_q | wd;
        ADDR_CLEAR: data_d = data_q & ~wd;
        default:    data_d = data_q;
      endcase
    end
  end

  // Read mux, sampled every clock from pre-edge state; reads have no side effects.
  always_comb begin
    readdata_d = '0;
    if (address == ADDR_PULSE) begin
      readdata_d[WIDTH-1:0] = pulse_mask;
      readdata_d[BUSY_BIT]  = readdata_d[BUSY_BIT] | busy;
    end else begin
      readdata_d[WIDTH-1:0] = data_q;
    end
  end

  // Pin value is registered from next-state values so it tracks the registers.
  always_comb begin
    out_d = data_d | pulse_mask_next;
  end

  // Register file, read data and output pin register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
      out_q      <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
      out_q      <= out_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_de2_115_web_qsys_pio_out.sv
// Self-checking bench for de2_115_web_qsys_pio_out (WIDTH=4, RESET_VALUE=5,
// PULSE_CYCLES=3). The reference model tracks the pulse as "the last cycle
// in which the mask is visible" rather than as a down-counter.
module tb_de2_115_web_qsys_pio_out;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'h5;
  localparam int         P  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  de2_115_web_qsys_pio_out #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  int          m_last;   // last cycle index in which m_mask drives the pins
  int          cyc;      // index of the cycle currently being presented
  logic [31:0] exp_rd;
  logic [3:0]  exp_out;

  function automatic logic [3:0] live_mask();
    return (cyc <= m_last) ? m_mask : 4'h0;
  endfunction

  // Present one bus cycle, advance the model, and leave the bench just after
  // the edge with exp_rd / exp_out describing what the DUT should now show.
  task automatic bus(input logic cs, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd);
    logic [3:0] cur;
    logic [3:0] w;
    cur = live_mask();
    w   = wd[3:0];
    exp_rd = (a == 2'd3) ? {(cur != 4'h0), 27'd0, cur} : {28'd0, m_data};
    if (cs && !wn) begin
      case (a)
        2'd0: m_data = w;
        2'd1: m_data = m_data | w;
        2'd2: m_data = m_data & ~w;
        default: if (w != 4'h0) begin
          m_mask = cur | w;
          m_last = cyc + P;
        end
      endcase
    end
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    #1;
    cyc++;
    exp_out    = m_data | live_mask();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset  = 1'b0;
    cyc   += n;
    m_data = RV;
    m_mask = 4'h0;
    m_last = -1;
    exp_rd = 32'd0;
    exp_out = RV;
  endtask

  task automatic test_reset();
    logic [31:0] want [4];
    want[0] = 32'h5; want[1] = 32'h5; want[2] = 32'h5; want[3] = 32'h0;
    do_reset(2);
    checks++;
    if (out_port !== 4'h5) begin
      errors++; $display("FAIL reset_out: got %h expected %h", out_port, 4'h5);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      bus(1'b1, 1'b1, 2'(a), 32'd0);
      checks++;
      if (readdata !== want[a]) begin
        errors++; $display("FAIL reset_read_a%0d: got %h expected %h", a, readdata, want[a]);
      end
    end
    $display("test_reset: out=%h", out_port);
  endtask

  task automatic test_data_write();
    bus(1'b1, 1'b0, 2'd0, 32'h3A);
    checks++;
    if (out_port !== 4'hA) begin
      errors++; $display("FAIL data_out: got %h expected %h", out_port, 4'hA);
    end
    bus(1'b1, 1'b1, 2'd0, 32'd0);
    checks++;
    if (readdata !== 32'h0000000A) begin
      errors++; $display("FAIL data_read: got %h expected %h", readdata, 32'hA);
    end
    $display("test_data_write: out=%h rd=%h", out_port, readdata);
  endtask

  task automatic test_set_clear();
    bus(1'b1, 1'b0, 2'd1, 32'h1);
    checks++;
    if (out_port !== 4'hB) begin
      errors++; $display("FAIL set_out: got %h expected %h", out_port, 4'hB);
    end
    bus(1'b1, 1'b0, 2'd2, 32'h8);
    checks++;
    if (out_port !== 4'h3) begin
      errors++; $display("FAIL clear_out: got %h expected %h", out_port, 4'h3);
    end
    $display("test_set_clear: out=%h", out_port);
  endtask

  task automatic test_pulse();
    logic [3:0] want [5];
    want[0] = 4'h4; want[1] = 4'h4; want[2] = 4'h4; want[3] = 4'h0; want[4] = 4'h0;
    bus(1'b1, 1'b0, 2'd0, 32'h0);
    bus(1'b1, 1'b0, 2'd3, 32'h4);           // cycle T
    checks++;
    if (out_port !== want[0]) begin
      errors++; $display("FAIL pulse_out_t1: got %h expected %h", out_port, want[0]);
    end
    bus(1'b1, 1'b1, 2'd3, 32'd0);           // read during T+1
    checks++;
    if (readdata !== 32'h80000004) begin
      errors++; $display("FAIL pulse_busy_read: got %h expected %h", readdata, 32'h80000004);
    end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (out_port !== want[k]) begin
        errors++; $display("FAIL pulse_out_t%0d: got %h expected %h", k + 1, out_port, want[k]);
      end
      if (k < 4) bus(1'b0, 1'b1, 2'd0, 32'd0);
    end
    bus(1'b1, 1'b1, 2'd3, 32'd0);           // read during T+5
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL pulse_idle_read: got %h expected %h", readdata, 32'h0);
    end
    $display("test_pulse: rd=%h out=%h", readdata, out_port);
  endtask

  task automatic test_retrigger();
    logic [3:0] want [6];
    want[0] = 4'h1; want[1] = 4'h1; want[2] = 4'h3; want[3] = 4'h3; want[4] = 4'h3; want[5] = 4'h0;
    bus(1'b1, 1'b0, 2'd3, 32'h1);           // T
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_port !== want[k]) begin
        errors++; $display("FAIL retrig_out_t%0d: got %h expected %h", k + 1, out_port, want[k]);
      end
      if (k == 1) bus(1'b1, 1'b0, 2'd3, 32'h2);   // T+2
      else if (k < 5) bus(1'b0, 1'b1, 2'd0, 32'd0);
    end
    $display("test_retrigger: out=%h", out_port);
  endtask

  task automatic test_reset_mid_pulse();
    bus(1'b1, 1'b0, 2'd3, 32'h4);
    checks++;
    if (out_port !== 4'h4) begin
      errors++; $display("FAIL midrst_pre: got %h expected %h", out_port, 4'h4);
    end
    do_reset(1);
    checks++;
    if (out_port !== 4'h5) begin
      errors++; $display("FAIL midrst_out: got %h expected %h", out_port, 4'h5);
    end
    bus(1'b1, 1'b1, 2'd3, 32'd0);
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL midrst_read: got %h expected %h", readdata, 32'h0);
    end
    $display("test_reset_mid_pulse: out=%h rd=%h", out_port, readdata);
  endtask

  task automatic test_random();
    logic        cs, wn;
    logic [1:0]  a;
    logic [31:0] wd;
    int          local_err;
    local_err = 0;
    for (int i = 0; i < 300; i++) begin
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 1) != 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd = wd & 32'hFFFF_FFF0;
      bus(cs, wn, a, wd);
      checks++;
      if (out_port !== exp_out) begin
        errors++; local_err++;
        $display("FAIL rand_out[%0d]: got %h expected %h", i, out_port, exp_out);
      end
      checks++;
      if (readdata !== exp_rd) begin
        errors++; local_err++;
        $display("FAIL rand_rd[%0d]: got %h expected %h", i, readdata, exp_rd);
      end
    end
    $display("test_random: 300 cycles, %0d mismatched", local_err);
  endtask

  initial begin
    cyc    = 0;
    m_data = RV;
    m_mask = 4'h0;
    m_last = -1;
    test_reset();
    test_data_write();
    test_set_clear();
    test_pulse();
    test_retrigger();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/de2_115_web_qsys_pio_out.md
# de2_115_web_qsys_pio_out

Avalon-MM slave parallel output port: the write-side counterpart of the system's read-only input PIOs (for example, the SD write-protect sense line). The Nios II software drives board control lines such as SD/LED/enable strobes through it. It provides a data register plus atomic bit-set and bit-clear access, and a self-timing pulse register, so firmware can strobe a pin for a fixed number of clocks without polling. It sits in the Qsys system on the peripheral clock domain, beside the input PIOs.

## Interface
Parameters:
- WIDTH, 1: output port width, 1..32.
- RESET_VALUE, 0: value of the data register after reset (WIDTH bits).
- PULSE_CYCLES, 4: pulse length in clocks, 1..65535.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits [31:WIDTH] are ignored.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  pin output = data_reg | pulse_mask.

## Operation
Register map:
- Address 0, DATA:
  - Write: data_reg <= writedata[WIDTH-1:0].
  - Read: data_reg.
- Address 1, SET:
  - Write: data_reg <= data_reg | wd.
  - Read: data_reg.
- Address 2, CLEAR:
  - Write: data_reg <= data_reg & ~wd.
  - Read: data_reg.
- Address 3, PULSE:
  - Write with a nonzero wd: pulse_mask <= pulse_mask | wd, and the counter reloads to PULSE_CYCLES-1.
  - Write with wd=0: no effect.
  - Read: bit 31 = busy (pulse_mask != 0), bits [WIDTH-1:0] = pulse_mask, all other bits 0.

Pulse timer:
- State IDLE (pulse_mask = 0) moves to ACTIVE on a nonzero PULSE write.
- In ACTIVE, the counter decrements each cycle. When the counter = 0 and there is no PULSE write in that cycle, pulse_mask <= 0 and the state returns to IDLE.
- A PULSE write while ACTIVE ORs the new bits into the mask and restarts the full PULSE_CYCLES window for all mask bits (retrigger).

General rules:
- Reads have no side effects.
- readdata bits above WIDTH (and bit 31 except on the PULSE read) are always 0.
- Only one address is accessed per cycle, so register-write conflicts cannot occur. A PULSE write never touches data_reg.
- A pulse bit that is also set in data_reg stays high after the pulse ends (the OR rule).

Reset values:
- data_reg = RESET_VALUE, pulse_mask = 0, counter = 0, readdata = 0, out_port = RESET_VALUE.
- Reset in the middle of a pulse aborts it immediately (out_port = RESET_VALUE on the next edge).

## Timing
- Write accepted at rising edge T; out_port reflects the new value from T+1 (out_port is a registered output, with no combinational path from writedata).
- Read latency is 1 clock:
  - readdata is sampled every clock from the address mux, so readdata at T+1 reflects address at T and register state before edge T.
  - There is no waitrequest.
- Pulse write at T: the pulse bits are high for exactly PULSE_CYCLES clocks, from T+1 through T+PULSE_CYCLES, then low at T+PULSE_CYCLES+1.
- With PULSE_CYCLES=1: a one-clock pulse.
- Retrigger write at T2: the pulse ends after T2+PULSE_CYCLES.
- Counter width is 16 bits. The counter never wraps: decrement occurs only when counter != 0.

## Structure
- Shared package: address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLEAR=2, ADDR_PULSE=3, and the busy bit index BUSY_BIT=31.
- One sub-module, de2_115_web_qsys_pio_pulse_timer:
  - Holds pulse_mask and the counter.
  - Inputs: load strobe and mask.
  - Outputs: pulse_mask and busy.
- The top level holds the decode, data_reg, the read mux and the output register.

## Test plan
Bench parameters: WIDTH=4, RESET_VALUE=4'h5, PULSE_CYCLES=3.
- Reset then read all four addresses -> out_port=4'h5; readdata=0x5, 0x5, 0x5, 0x0.
- Write 0x3A to DATA -> out_port=4'hA from the next clock; read DATA returns 0x0000000A.
- From 4'hA, write SET 0x1, then CLEAR 0x8 -> out_port=4'hB, then 4'h3; no glitch between them.
- With data_reg=0, write PULSE 0x4 at T -> out_port=4'h4 on T+1..T+3 and 0 at T+4; read PULSE at T+1 returns 0x80000004; read at T+5 returns 0.
- Pulse 0x1 at T, retrigger 0x2 at T+2 -> bit0 and bit1 both high through T+5, both low at T+6.
- Reset asserted mid-pulse at T+1 -> out_port=4'h5 at T+2, and PULSE reads 0.
